// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, ALU ops,
// ALU-B selects, FSM state codes and the decoded instruction-class payload.
package controller_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_LD   = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_ST   = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_BZ   = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [1:0] ALUB_ONE  = 2'd2;
    localparam logic [1:0] ALUB_DISP = 2'd3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_FETCH    = 3'd1;
    localparam state_t S_DECODE   = 3'd2;
    localparam state_t S_EXEC     = 3'd3;
    localparam state_t S_MEM_ADDR = 3'd4;
    localparam state_t S_MEM_WB   = 3'd5;
    localparam state_t S_HALT     = 3'd6;

    typedef struct packed {
        logic       alu;
        logic       addi;
        logic       jmp;
        logic       bz;
        logic       ld;
        logic       st;
        logic       halt;
        logic       illegal;
        logic [1:0] aluop;
    } insn_class_t;

endpackage

// File: rtl/controller_decode.sv
// Combinational opcode decoder: maps the IR opcode to an instruction class
// and the ALU operation used by register-register instructions.
module controller_decode
    import controller_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output insn_class_t         cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD:  begin cls.alu = 1'b1; cls.aluop = ALU_ADD; end
            OP_SUB:  begin cls.alu = 1'b1; cls.aluop = ALU_SUB; end
            OP_AND:  begin cls.alu = 1'b1; cls.aluop = ALU_AND; end
            OP_OR:   begin cls.alu = 1'b1; cls.aluop = ALU_OR;  end
            OP_ADDI: cls.addi = 1'b1;
            OP_LD:   cls.ld   = 1'b1;
            OP_ST:   cls.st   = 1'b1;
            OP_JMP:  cls.jmp  = 1'b1;
            OP_BZ:   cls.bz   = 1'b1;
            OP_HALT: cls.halt = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Multicycle control FSM for the 32-bit CPU datapath (fetch/decode/exec/mem).
// Define CONTROLLER_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT with a sticky illegal flag.
module controller
    import controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                n,
    input  logic                v,
    input  logic                c,
    output logic                writepc,
    output logic                selldst,
    output logic                writemem,
    output logic                writeir,
    output logic                selload,
    output logic                selst,
    output logic                writereg,
    output logic                selalua,
    output logic [1:0]          selalub,
    output logic [1:0]          aluop,
    output logic                writezero,
    output logic                busy,
    output logic                halted
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    state_t      state;
    state_t      state_nxt;
    insn_class_t cls;

    // ALU flags are part of the datapath contract but no instruction reads them yet
    logic unused_flags;
    assign unused_flags = &{1'b0, n, v, c};

    controller_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

`ifdef CONTROLLER_ILLEGAL_TRAP_EN
    // Sticky trap flag, set on the DECODE cycle that dispatches to HALT
    always_ff @(posedge clk) begin
        if (rst)                                     illegal <= 1'b0;
        else if (state == S_DECODE && cls.illegal)   illegal <= 1'b1;
    end
`endif

    always_comb begin
        state_nxt = state;
        writepc   = 1'b0;
        selldst   = 1'b0;
        writemem  = 1'b0;
        writeir   = 1'b0;
        selload   = 1'b0;
        selst     = 1'b0;
        writereg  = 1'b0;
        selalua   = 1'b0;
        selalub   = ALUB_REG;
        aluop     = ALU_ADD;
        writezero = 1'b0;
        busy      = (state != S_IDLE) && (state != S_HALT);
        halted    = (state == S_HALT);

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                writeir   = 1'b1;
                writepc   = 1'b1;
                selalua   = 1'b1;
                selalub   = ALUB_ONE;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (cls.alu || cls.addi || cls.jmp || cls.bz) state_nxt = S_EXEC;
                else if (cls.ld || cls.st)                    state_nxt = S_MEM_ADDR;
                else if (cls.halt)                            state_nxt = S_HALT;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
                else                                          state_nxt = S_HALT;
`else
                else                                          state_nxt = S_FETCH;
`endif
            end
            S_EXEC: begin
                if (cls.alu) begin
                    aluop     = cls.aluop;
                    writereg  = 1'b1;
                    writezero = 1'b1;
                end else if (cls.addi) begin
                    selalub   = ALUB_IMM;
                    selst     = 1'b1;
                    writereg  = 1'b1;
                    writezero = 1'b1;
                end else begin
                    // JMP and BZ share the PC+1+disp target; BZ gates the load on zero
                    selalua = 1'b1;
                    selalub = ALUB_DISP;
                    writepc = cls.jmp | (cls.bz & zero);
                end
                state_nxt = S_FETCH;
            end
            S_MEM_ADDR: begin
                selalub   = ALUB_IMM;
                selldst   = 1'b1;
                writemem  = cls.st;
                state_nxt = cls.ld ? S_MEM_WB : S_FETCH;
            end
            S_MEM_WB: begin
                selalub   = ALUB_IMM;
                selldst   = 1'b1;
                selload   = 1'b1;
                selst     = 1'b1;
                writereg  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: per-instruction expected output
// sequences built from the instruction table, checked cycle by cycle.
module tb_controller;

    typedef struct packed {
        logic       writepc;
        logic       selldst;
        logic       writemem;
        logic       writeir;
        logic       selload;
        logic       selst;
        logic       writereg;
        logic       selalua;
        logic [1:0] selalub;
        logic [1:0] aluop;
        logic       writezero;
        logic       busy;
        logic       halted;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       n = 1'b0, v = 1'b0, c = 1'b0;
    logic       writepc, selldst, writemem, writeir, selload, selst, writereg;
    logic       selalua, writezero, busy, halted;
    logic [1:0] selalub, aluop;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int checks = 0;
    int errors = 0;
    ctl_t act;
    ctl_t exp_q[$];

    assign act = {writepc, selldst, writemem, writeir, selload, selst, writereg,
                  selalua, selalub, aluop, writezero, busy, halted};

    always #5 clk = ~clk;

    controller dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
        .n(n), .v(v), .c(c),
        .writepc(writepc), .selldst(selldst), .writemem(writemem), .writeir(writeir),
        .selload(selload), .selst(selst), .writereg(writereg), .selalua(selalua),
        .selalub(selalub), .aluop(aluop), .writezero(writezero), .busy(busy),
        .halted(halted)
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs for one instruction, starting at its FETCH cycle
    function automatic void gen(input logic [5:0] op, input logic z);
        ctl_t f, d, e, w;
        exp_q.delete();
        f = '0; f.writeir = 1'b1; f.writepc = 1'b1; f.selalua = 1'b1;
        f.selalub = 2'd2; f.busy = 1'b1;
        d = '0; d.busy = 1'b1;
        e = '0; e.busy = 1'b1;
        w = '0; w.busy = 1'b1;
        exp_q.push_back(f);
        exp_q.push_back(d);
        if (op >= 6'd1 && op <= 6'd4) begin
            e.aluop = 2'(op - 6'd1); e.writereg = 1'b1; e.writezero = 1'b1;
            exp_q.push_back(e);
        end else if (op == 6'd5) begin
            e.selalub = 2'd1; e.selst = 1'b1; e.writereg = 1'b1; e.writezero = 1'b1;
            exp_q.push_back(e);
        end else if (op == 6'd8 || op == 6'd9) begin
            e.selalua = 1'b1; e.selalub = 2'd3; e.writepc = (op == 6'd8) ? 1'b1 : z;
            exp_q.push_back(e);
        end else if (op == 6'd6) begin
            e.selalub = 2'd1; e.selldst = 1'b1;
            w = e; w.selload = 1'b1; w.selst = 1'b1; w.writereg = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(w);
        end else if (op == 6'd7) begin
            e.selalub = 2'd1; e.selldst = 1'b1; e.writemem = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic z, input string name);
        opcode = op;
        zero   = z;
        gen(op, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (act !== exp_q[i]) begin
                errors++;
                $display("FAIL %s op=%b cyc%0d: got %h expected %h", name, op, i, act, exp_q[i]);
            end
            step();
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (act !== ctl_t'(0)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, ctl_t'(0));
        end
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s illegal: got %b expected 0", name, illegal);
        end
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("idle_no_start");
        end
        do_start();
    endtask

    task automatic test_sub();
        run_instr(6'b000010, 1'b0, "sub");
    endtask

    task automatic test_ld();
        run_instr(6'b000110, 1'b0, "ld");
    endtask

    task automatic test_bz();
        run_instr(6'b001001, 1'b0, "bz_not_taken");
        run_instr(6'b001001, 1'b1, "bz_taken");
    endtask

    task automatic test_back_to_back();
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        logic [5:0] ops[10] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd1};
`else
        logic [5:0] ops[10] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'h15};
`endif
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 9)];
            run_instr(op, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_rst_mid();
        opcode = 6'b000110;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_mid_instr");
        step();
        check_idle("rst_mid_idle");
        do_start();
    endtask

    task automatic test_halt();
        ctl_t h;
        h = '0; h.halted = 1'b1;
        gen(6'b111111, 1'b0);
        run_instr(6'b111111, 1'b0, "halt_entry");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (act !== h) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: got %h expected %h", i, act, h);
            end
            start = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("halt_reset");
        do_start();
    endtask

    task automatic test_illegal();
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        ctl_t h;
        h = '0; h.halted = 1'b1;
        run_instr(6'b010101, 1'b0, "illegal_entry");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act !== h || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_trap cyc%0d: got %h/%b expected %h/1", i, act, illegal, h);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("illegal_reset");
`else
        run_instr(6'b010101, 1'b0, "illegal_nop");
        run_instr(6'b000001, 1'b0, "after_nop");
`endif
    endtask

    initial begin
        test_reset();
        test_sub();
        test_ld();
        test_bz();
        test_back_to_back();
        test_rst_mid();
        test_halt();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller.md
# controller

Multicycle control FSM that drives the 32-bit CPU datapath. Consumes the datapath's `opcode` and registered `zero` flag and generates every write-enable, mux select and ALU op per cycle. It sequences fetch, decode, execute and memory steps. It sits beside the datapath in the CPU top and idles while the testbench preloads memory.

## Interface
Parameters: none; all encodings are constants in the package.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse to leave IDLE and begin fetch at the current PC.
- `opcode` in 6: instruction opcode from the datapath (IR[31:26]).
- `zero` in 1: registered zero flag from the datapath.
- `n`, `v`, `c` in 1 each: ALU flags; accepted but unused by the current ISA.
- `writepc` out 1: PC load enable.
- `selldst` out 1: memory address select; 0 = PC, 1 = ALU[4:0].
- `writemem` out 1: memory write enable.
- `writeir` out 1: IR load enable.
- `selload` out 1: register write-data select; 0 = ALU, 1 = memory.
- `selst` out 1: register write-address select; 0 = IR[4:0], 1 = IR[25:21].
- `writereg` out 1: register-file write enable.
- `selalua` out 1: ALU A select; 0 = R[IR25:21], 1 = PC.
- `selalub` out 2: ALU B select; 0 = R[IR20:16], 1 = sign-extended imm16, 2 = const 1, 3 = sign-extended disp26.
- `aluop` out 2: ALU operation; 00 ADD, 01 SUB, 10 AND, 11 OR.
- `writezero` out 1: zero-flag load enable.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM_ADDR, MEM_WB, HALT.
- Every control output defaults to 0 in every state; each state asserts only what is listed here.
- IDLE: stay until `start` = 1, then go to FETCH.
- FETCH: asserts `writeir`, `writepc`, `selalua`=1, `selalub`=2, `aluop`=ADD. IR loads M[PC] and the PC increments in the same cycle. Next state is DECODE.
- DECODE: no outputs. Opcode dispatch:
  - ALU ops, ADDI, JMP and BZ go to EXEC.
  - LD and ST go to MEM_ADDR.
  - HALT goes to HALT.
  - Undefined opcodes: see Configuration.
- Opcodes and their EXEC actions (EXEC then returns to FETCH):
  - ADD 000001, SUB 000010, AND 000011, OR 000100: `selalua`=0, `selalub`=0, `aluop`=op, `selst`=0, `writereg`, `writezero`. Result is R[IR4:0] ← R[IR25:21] op R[IR20:16].
  - ADDI 000101: `selalub`=1, ADD, `selst`=1, `writereg`, `writezero`. Result is R[IR25:21] ← R[IR25:21] + imm.
  - JMP 001000: `selalua`=1, `selalub`=3, ADD, `writepc`. Result is PC ← PC+1+disp.
  - BZ 001001: same selects as JMP; `writepc` = `zero`.
- Memory ops:
  - LD 000110: MEM_ADDR drives `selalub`=1, ADD, `selldst`=1, then goes to MEM_WB. MEM_WB holds the same selects and adds `selload`, `selst`=1, `writereg`, then goes to FETCH. Result is R[IR25:21] ← M[R[IR25:21]+imm].
  - ST 000111: MEM_ADDR drives the same selects plus `writemem`, then goes to FETCH. Result is M[R[IR25:21]+imm] ← R[IR20:16].
- HALT 111111: terminal state; only `rst` leaves it.

## Timing
- Reset: state is IDLE and every output is 0, including `busy` and `halted`.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - ALU ops, ADDI, JMP, BZ, ST: 3 cycles.
  - LD: 4 cycles.
- Outputs are a Moore decode of the state register, plus the opcode/`zero` terms in EXEC and MEM_ADDR. `opcode` must be stable from DECODE onward.
- `start` is ignored outside IDLE.
- `rst` mid-instruction wins on the next edge: state returns to IDLE and no write enable is asserted in that cycle's output.
- BZ samples the `zero` flag stored by the last ALU/ADDI instruction.

## Configuration
- `CONTROLLER_ILLEGAL_TRAP_EN` defined: an undefined opcode in DECODE goes to HALT and raises an extra output `illegal` (1 bit). `illegal` is sticky until `rst` and resets to 0.
- Macro undefined: an undefined opcode returns from DECODE to FETCH as a 2-cycle NOP, and the `illegal` port does not exist.

## Structure
- `controller_pkg` holds:
  - opcode constants;
  - `aluop` codes;
  - `selalub` codes;
  - the state enum.
- One sub-module, `controller_decode`: combinational opcode → instruction class (alu, addi, jmp, bz, ld, st, halt, illegal) plus the `aluop` field. The FSM in `controller` uses its outputs.

## Test plan
- Reset, then idle 5 cycles with `start`=0 → all outputs stay 0 and the state stays IDLE. A `start` pulse → FETCH outputs next cycle, with `writeir`=`writepc`=1 and `selalub`=2.
- Opcode 000010 (SUB) → EXEC drives `aluop`=01, `writereg`=1, `writezero`=1, `selst`=0. FETCH follows exactly 3 cycles after the previous FETCH.
- Opcode 000110 (LD) → MEM_ADDR drives `selldst`=1, `selalub`=1. MEM_WB drives `selload`=`writereg`=`selst`=1. Total 4 cycles.
- Opcode 001001 (BZ) with `zero`=0 → `writepc`=0 in EXEC. With `zero`=1 → `writepc`=1, `selalua`=1, `selalub`=3.
- Opcode 111111 → `halted`=1 and `busy`=0, held for 10 cycles despite `start` pulses. `rst`=1 → IDLE.
- Opcode 010101: with the macro defined → HALT and `illegal`=1. Without the macro → FETCH 2 cycles after the previous FETCH.
